// File: rtl/food_placer.sv
// Food placement controller: PRNG retries, then a linear scan of the 8x8 board.
// Optional FOOD_WATCHDOG_EN bounds the wait for rng_ack and falls back to scanning.
module food_placer #(
    parameter int         MAX_TRIES = 4,
    parameter logic [5:0] FOOD_INIT = 6'd36
`ifdef FOOD_WATCHDOG_EN
    ,
    parameter int         RNG_TIMEOUT = 16
`endif
) (
    input  logic        clka,
    input  logic        restart_n,
    input  logic        place_req,
    input  logic [63:0] occupied_flat,
    output logic        rng_req,
    input  logic        rng_ack,
    input  logic [5:0]  rng_value,
    output logic [5:0]  food_pos,
    output logic        place_done,
    output logic        board_full,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CHECK,
        S_SCAN,
        S_DONE
    } state_t;

    state_t     r_state, w_next;
    logic [5:0] r_cand, w_cand;
    logic [3:0] r_try, w_try;
    logic [5:0] r_sidx, w_sidx;
    logic [5:0] r_scnt, w_scnt;
    logic [5:0] r_food, w_food;
    logic       r_full, w_full;
    logic       r_rng_req;
    logic       r_busy;
    logic       r_done;

`ifdef FOOD_WATCHDOG_EN
    localparam int WDW = $clog2(RNG_TIMEOUT + 1);
    logic [WDW-1:0] r_wd;
    logic           w_wd_expired;

    assign w_wd_expired = (r_wd == WDW'(RNG_TIMEOUT - 1));

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) r_wd <= '0;
        else if (r_state == S_REQ) r_wd <= r_wd + WDW'(1);
        else r_wd <= '0;
    end
`endif

    always_comb begin
        w_next = r_state;
        w_cand = r_cand;
        w_try  = r_try;
        w_sidx = r_sidx;
        w_scnt = r_scnt;
        w_food = r_food;
        w_full = r_full;
        case (r_state)
            S_IDLE: begin
                if (place_req) begin
                    w_next = S_REQ;
                    w_try  = 4'd0;
                    w_full = 1'b0;
                end
            end
            S_REQ: begin
                if (rng_ack) begin
                    w_cand = rng_value;
                    w_next = S_CHECK;
                end
`ifdef FOOD_WATCHDOG_EN
                else if (w_wd_expired) begin
                    w_sidx = r_food + 6'd1;
                    w_scnt = 6'd0;
                    w_next = S_SCAN;
                end
`endif
            end
            S_CHECK: begin
                if (!occupied_flat[r_cand]) begin
                    w_food = r_cand;
                    w_next = S_DONE;
                end else begin
                    w_try = r_try + 4'd1;
                    if (w_try == 4'(MAX_TRIES)) begin
                        w_sidx = r_cand + 6'd1;
                        w_scnt = 6'd0;
                        w_next = S_SCAN;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_SCAN: begin
                if (!occupied_flat[r_sidx]) begin
                    w_food = r_sidx;
                    w_next = S_DONE;
                end else if (r_scnt == 6'd63) begin
                    // every cell has now been examined once
                    w_full = 1'b1;
                    w_next = S_DONE;
                end else begin
                    w_sidx = r_sidx + 6'd1;
                    w_scnt = r_scnt + 6'd1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_state   <= S_IDLE;
            r_cand    <= 6'd0;
            r_try     <= 4'd0;
            r_sidx    <= 6'd0;
            r_scnt    <= 6'd0;
            r_food    <= FOOD_INIT;
            r_full    <= 1'b0;
            r_rng_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cand    <= w_cand;
            r_try     <= w_try;
            r_sidx    <= w_sidx;
            r_scnt    <= w_scnt;
            r_food    <= w_food;
            r_full    <= w_full;
            r_rng_req <= (w_next == S_REQ);
            r_busy    <= (w_next != S_IDLE);
            r_done    <= (w_next == S_DONE);
        end
    end

    assign rng_req    = r_rng_req;
    assign busy       = r_busy;
    assign place_done = r_done;
    assign food_pos   = r_food;
    assign board_full = r_full;

endmodule

// File: tb/tb_food_placer.sv
// Directed self-checking bench for food_placer.
// Exercises the watchdog path when FOOD_WATCHDOG_EN is defined.
module tb_food_placer;

    logic        clka = 1'b0;
    logic        restart_n;
    logic        place_req;
    logic [63:0] occupied_flat;
    logic        rng_req;
    logic        rng_ack;
    logic [5:0]  rng_value;
    logic [5:0]  food_pos;
    logic        place_done;
    logic        board_full;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    food_placer dut (
        .clka          (clka),
        .restart_n     (restart_n),
        .place_req     (place_req),
        .occupied_flat (occupied_flat),
        .rng_req       (rng_req),
        .rng_ack       (rng_ack),
        .rng_value     (rng_value),
        .food_pos      (food_pos),
        .place_done    (place_done),
        .board_full    (board_full),
        .busy          (busy)
    );

    always #5 clka = ~clka;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic pulse_req();
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
    endtask

    // wait for rng_req, then answer with a one-cycle ack carrying v
    task automatic rng_resp(input string tag, input logic [5:0] v);
        int i;
        i = 0;
        while (!rng_req && i < 20) begin
            tick();
            i++;
        end
        chk({tag, "_rngreq"}, rng_req, 1'b1);
        rng_ack   = 1'b1;
        rng_value = v;
        tick();
        rng_ack   = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!place_done && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    int seen;

    initial begin
        restart_n     = 1'b0;
        place_req     = 1'b0;
        occupied_flat = '0;
        rng_ack       = 1'b0;
        rng_value     = 6'd0;
        tick();
        tick();
        chk("rst_food", food_pos, 6'd36);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rngreq", rng_req, 1'b0);
        chk("rst_done", place_done, 1'b0);
        chk("rst_full", board_full, 1'b0);
        restart_n = 1'b1;
        tick();

        // reset while a PRNG request is outstanding
        pulse_req();
        chk("mid_rngreq_hi", rng_req, 1'b1);
        restart_n = 1'b0;
        #1;
        chk("mid_rngreq", rng_req, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", place_done, 1'b0);
        chk("mid_food", food_pos, 6'd36);
        tick();
        restart_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            rng_ack   = 1'b1;
            rng_value = 6'd3;
            tick();
            rng_ack = 1'b0;
            if (place_done || busy) seen++;
        end
        chk("mid_quiet", seen, 0);

        // free first candidate, exact latency
        occupied_flat = '0;
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        chk("ff_rngreq", rng_req, 1'b1);
        chk("ff_busy", busy, 1'b1);
        rng_ack   = 1'b1;
        rng_value = 6'd10;
        tick();
        rng_ack = 1'b0;
        chk("ff_check_rngreq", rng_req, 1'b0);
        chk("ff_check_done", place_done, 1'b0);
        tick();
        chk("ff_done", place_done, 1'b1);
        chk("ff_food", food_pos, 6'd10);
        place_req = 1'b1;
        tick();
        place_req = 1'b0;
        chk("ff_idle_busy", busy, 1'b0);
        chk("ff_idle_done", place_done, 1'b0);
        // request in the first IDLE cycle is accepted
        pulse_req();
        chk("b2b_busy", busy, 1'b1);
        rng_resp("b2b", 6'd11);
        wait_done(10, cyc);
        chk("b2b_done", place_done, 1'b1);
        chk("b2b_food", food_pos, 6'd11);
        tick();

        // retry on occupied candidates
        occupied_flat = (64'd1 << 10) | (64'd1 << 20);
        pulse_req();
        rng_resp("rt1", 6'd10);
        rng_resp("rt2", 6'd20);
        rng_resp("rt3", 6'd30);
        wait_done(10, cyc);
        chk("rt_done", place_done, 1'b1);
        chk("rt_food", food_pos, 6'd30);
        chk("rt_full", board_full, 1'b0);
        tick();

        // four misses then scan 63, 0, 1
        occupied_flat = ~(64'd1 << 1);
        pulse_req();
        for (int t = 0; t < 4; t++) rng_resp("sw", 6'd62);
        wait_done(20, cyc);
        chk("sw_cycles", cyc, 4);
        chk("sw_done", place_done, 1'b1);
        chk("sw_food", food_pos, 6'd1);
        tick();

        // completely full board
        occupied_flat = '1;
        pulse_req();
        for (int t = 0; t < 4; t++) rng_resp("bf", 6'd7);
        wait_done(100, cyc);
        chk("bf_cycles", cyc, 65);
        chk("bf_done", place_done, 1'b1);
        chk("bf_full", board_full, 1'b1);
        chk("bf_food", food_pos, 6'd1);
        tick();
        chk("bf_full_held", board_full, 1'b1);
        occupied_flat = '0;
        pulse_req();
        chk("bf_full_clr", board_full, 1'b0);
        rng_resp("bf2", 6'd9);
        wait_done(10, cyc);
        chk("bf2_food", food_pos, 6'd9);
        tick();

`ifdef FOOD_WATCHDOG_EN
        pulse_req();
        rng_resp("wd0", 6'd5);
        wait_done(10, cyc);
        chk("wd_food5", food_pos, 6'd5);
        tick();
        occupied_flat = ~(64'd1 << 7);
        pulse_req();
        seen = 0;
        while (rng_req && seen < 40) begin
            tick();
            seen++;
        end
        chk("wd_req_cycles", seen, 16);
        wait_done(10, cyc);
        chk("wd_scan_cycles", cyc, 2);
        chk("wd_food", food_pos, 6'd7);
`else
        pulse_req();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rng_req) seen++;
            tick();
        end
        chk("nowd_req_held", seen, 40);
        chk("nowd_busy", busy, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
